fifo_push_arbiter: RTL and testbench

Round-robin arbiter that shares the single push port of a flop-based FIFO among `n_req` producers. Each producer wins a tenure of up to `max_burst` consecutive pushes. The arbiter never pushes into a full FIFO, so its `push`/`write_data` outputs connect directly to the FIFO and to `fifo_monitor` with `allow_push_when_full_with_pop = 0`.

---
 rtl/fifo_push_arbiter_if.sv | 26 ++
 rtl/fifo_push_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_push_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fifo_push_arbiter_if.sv
// Producer-side and FIFO-side signals of the shared push port.
interface fifo_push_arbiter_if #(
  parameter int unsigned width = 8,
  parameter int unsigned n_req = 3
);
  localparam int unsigned id_w = (n_req > 1) ? $clog2(n_req) : 1;

  logic [n_req-1:0]       req_valid;
  logic [n_req*width-1:0] req_data;
  logic [n_req-1:0]       req_ready;
  logic                   fifo_full;
  logic                   push;
  logic [width-1:0]       write_data;
  logic                   grant_valid;
  logic [id_w-1:0]        grant_id;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, push, write_data, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, push, write_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port; each owner gets a tenure of
// up to max_burst pushes and never pushes into a full FIFO.
module fifo_push_arbiter #(
  parameter int unsigned width     = 8,
  parameter int unsigned n_req     = 3,
  parameter int unsigned max_burst = 2
) (
  input logic               clk,
  input logic               rst,
  fifo_push_arbiter_if.master bus
);
  localparam int unsigned id_w  = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int unsigned cnt_w = $clog2(max_burst + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           st, st_nxt;
  logic [id_w-1:0]  owner, owner_nxt, ptr, ptr_nxt, ptr_rel, winner;
  logic [cnt_w-1:0] cnt, cnt_nxt;
  logic             found, own_valid, push_c;
  logic [width-1:0] own_data;
  logic [n_req-1:0] ready_c;

  // Rotating priority: first valid at or above ptr, else lowest valid below it.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (!found && bus.req_valid[i] && (32'(ptr) <= i)) begin
        found  = 1'b1;
        winner = id_w'(i);
      end
    end
    for (int unsigned i = 0; i < n_req; i++) begin
      if (!found && bus.req_valid[i]) begin
        found  = 1'b1;
        winner = id_w'(i);
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (owner == id_w'(i)) begin
        own_valid = bus.req_valid[i];
        own_data  = bus.req_data[i*width +: width];
      end
    end
  end

  assign ptr_rel = (owner == id_w'(n_req - 1)) ? '0 : owner + id_w'(1);

  always_comb begin
    st_nxt    = st;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    push_c    = 1'b0;
    ready_c   = '0;
    case (st)
      IDLE: begin
        if (found) begin
          owner_nxt = winner;
          cnt_nxt   = '0;
          st_nxt    = OWN;
        end
      end
      OWN: begin
        for (int unsigned i = 0; i < n_req; i++) begin
          ready_c[i] = (owner == id_w'(i)) && !bus.fifo_full;
        end
        push_c = own_valid && !bus.fifo_full;
        if (push_c) begin
          cnt_nxt = cnt + cnt_w'(1);
          if (cnt == cnt_w'(max_burst - 1)) begin
            st_nxt  = IDLE;
            ptr_nxt = ptr_rel;
          end
        end else if (!own_valid) begin
          st_nxt  = IDLE;
          ptr_nxt = ptr_rel;
        end
      end
    endcase
    if (rst) begin
      push_c  = 1'b0;
      ready_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      st    <= st_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign bus.push        = push_c;
  assign bus.req_ready   = ready_c;
  assign bus.write_data  = own_data;
  assign bus.grant_valid = (st == OWN) && !rst;
  assign bus.grant_id    = owner;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench: expected pushes queued by the stimulus, popped by a monitor.
module tb_fifo_push_arbiter;
  localparam int unsigned width     = 8;
  localparam int unsigned n_req     = 3;
  localparam int unsigned max_burst = 2;
  localparam int unsigned id_w      = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  logic [id_w+width-1:0] exp_q[$];
  logic [id_w+width-1:0] exp_w;

  always #5 clk = ~clk;

  fifo_push_arbiter_if #(.width(width), .n_req(n_req)) bus();

  fifo_push_arbiter #(.width(width), .n_req(n_req), .max_burst(max_burst)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic expect_push(input int id, input int n);
    logic [width-1:0] d;
    d = 8'hA0 + width'(id);
    repeat (n) exp_q.push_back({id_w'(id), d});
  endtask

  // One cycle: check control outputs at the negedge, then advance past posedge.
  task automatic cyc(input logic gv, input int id, input logic [n_req-1:0] rdy, input logic psh);
    @(negedge clk);
    checks++;
    if (bus.grant_valid !== gv) begin
      errors++;
      $display("FAIL grant_valid cyc=%0d got=%b exp=%b", cyc_no, bus.grant_valid, gv);
    end
    if (gv) begin
      checks++;
      if (bus.grant_id !== id_w'(id)) begin
        errors++;
        $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc_no, bus.grant_id, id);
      end
    end
    checks++;
    if (bus.req_ready !== rdy) begin
      errors++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc_no, bus.req_ready, rdy);
    end
    checks++;
    if (bus.push !== psh) begin
      errors++;
      $display("FAIL push cyc=%0d got=%b exp=%b", cyc_no, bus.push, psh);
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 3'b000, 1'b0);
  endtask

  // Scoreboard monitor: every push must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.push === 1'b1) begin
      checks++;
      if (bus.fifo_full !== 1'b0) begin
        errors++;
        $display("FAIL push_when_full cyc=%0d got fifo_full=%b exp=0", cyc_no, bus.fifo_full);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_push cyc=%0d got id=%0d data=%h exp none",
                 cyc_no, bus.grant_id, bus.write_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.grant_id, bus.write_data} !== exp_w) begin
          errors++;
          $display("FAIL push_data cyc=%0d got id=%0d data=%h exp id=%0d data=%h", cyc_no,
                   bus.grant_id, bus.write_data, exp_w[width+id_w-1:width], exp_w[width-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 3'b111;
    bus.req_data  = {8'hA2, 8'hA1, 8'hA0};
    bus.fifo_full = 1'b0;

    // Reset held 3 cycles with all requesters valid
    repeat (3) idle();
    rst = 1'b0;

    // Round robin, then backpressure on owner 1 at cnt=1
    expect_push(0, 2); expect_push(1, 2); expect_push(2, 2);
    expect_push(0, 2); expect_push(1, 2); expect_push(2, 2);
    idle();
    repeat (2) cyc(1'b1, 0, 3'b001, 1'b1);
    idle();
    repeat (2) cyc(1'b1, 1, 3'b010, 1'b1);
    idle();
    repeat (2) cyc(1'b1, 2, 3'b100, 1'b1);
    idle();
    repeat (2) cyc(1'b1, 0, 3'b001, 1'b1);
    idle();
    cyc(1'b1, 1, 3'b010, 1'b1);
    bus.fifo_full = 1'b1;
    repeat (3) cyc(1'b1, 1, 3'b000, 1'b0);
    bus.fifo_full = 1'b0;
    cyc(1'b1, 1, 3'b010, 1'b1);
    bus.req_valid = 3'b101;
    idle();
    repeat (2) cyc(1'b1, 2, 3'b100, 1'b1);
    bus.req_valid = 3'b000;
    idle();

    // Early release: requester 1 supplies one word then drops valid
    expect_push(1, 1); expect_push(2, 2);
    bus.req_valid = 3'b010;
    idle();
    cyc(1'b1, 1, 3'b010, 1'b1);
    bus.req_valid = 3'b000;
    cyc(1'b1, 1, 3'b010, 1'b0);
    bus.req_valid = 3'b101;
    idle();
    repeat (2) cyc(1'b1, 2, 3'b100, 1'b1);
    bus.req_valid = 3'b000;
    idle();

    // Skip to requester 2, wrap back to 0
    expect_push(2, 2); expect_push(0, 2);
    bus.req_valid = 3'b100;
    idle();
    repeat (2) cyc(1'b1, 2, 3'b100, 1'b1);
    bus.req_valid = 3'b101;
    idle();
    repeat (2) cyc(1'b1, 0, 3'b001, 1'b1);
    bus.req_valid = 3'b000;
    idle();

    // Reset mid-tenure with owner 2 at cnt=1
    expect_push(2, 1); expect_push(0, 2);
    bus.req_valid = 3'b100;
    idle();
    cyc(1'b1, 2, 3'b100, 1'b1);
    rst           = 1'b1;
    bus.req_valid = 3'b101;
    idle();
    rst = 1'b0;
    idle();
    repeat (2) cyc(1'b1, 0, 3'b001, 1'b1);
    bus.req_valid = 3'b000;
    repeat (3) idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
